gf_mul_ds: RTL and testbench

- Parametrised, digit-serial GF(2^M) multiplier with valid/ready handshakes on input and output.
- Successor to the fixed 8-bit combinational and LUT multipliers; field width, reduction polynomial and digit size are generics.
- Area/latency trade-off: D bits of b processed per cycle, constant latency of M/D cycles.
- Sits in the Reed-Solomon/codec datapath wherever an area-lean, handshaked multiplier is required.

---
 rtl/gf_mul_ds_if.sv | 34 +++
 rtl/gf_mul_ds.sv | 143 ++++++++++++++
 tb/tb_gf_mul_ds.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/gf_mul_ds_if.sv
// ---------------------------------------------------------------------------
// gf_mul_ds_if : operand / result handshake bundle for the digit-serial
//                GF(2^M) multiplier.
//
//   in_valid_i   operand pair valid              (master -> slave)
//   in_ready_o   multiplier can take operands    (slave  -> master)
//   a_i, b_i     multiplicand / multiplier, M b  (master -> slave)
//   out_valid_o  z_o holds a finished product    (slave  -> master)
//   out_ready_i  consumer accepts z_o            (master -> slave)
//   z_o          product a*b mod POLY, M bits    (slave  -> master)
//   busy_o       multiplier is in CALC or DONE   (slave  -> master)
// ---------------------------------------------------------------------------
interface gf_mul_ds_if #(
  parameter int unsigned M = 8
);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [M-1:0] a_i;
  logic [M-1:0] b_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [M-1:0] z_o;
  logic         busy_o;

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, z_o, busy_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, z_o, busy_o
  );
endinterface

// File: rtl/gf_mul_ds.sv
// ---------------------------------------------------------------------------
// gf_mul_ds : digit-serial GF(2^M) multiplier with valid/ready handshakes.
//
// Consumes D bits of b per clock, MSB first, using the interleaved
// shift-and-reduce (Horner) scheme, so a product takes M/D cycles after the
// operands are accepted, independent of the operand values.
//
// Parameters
//   M     field width, 2..16
//   POLY  low M bits of the reduction polynomial (x^M term implicit)
//   D     digit size; M must be a multiple of D
//
// Ports
//   clk_i  clock, rising edge
//   rst_i  asynchronous, active-high reset
//   bus    gf_mul_ds_if slave: in_valid_i/in_ready_o/a_i/b_i in,
//          out_valid_o/out_ready_i/z_o out, busy_o status
// ---------------------------------------------------------------------------
module gf_mul_ds #(
  parameter int unsigned  M    = 8,
  parameter logic [M-1:0] POLY = M'(8'h1D),
  parameter int unsigned  D    = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  gf_mul_ds_if.slave bus
);

  localparam int unsigned NCYC  = M / D;
  localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (M < 2 || M > 16) begin : g_bad_m
    $error("gf_mul_ds: M must be in 2..16");
  end
  if (D == 0 || (M % D) != 0) begin : g_bad_d
    $error("gf_mul_ds: M must be a non-zero multiple of D");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic [M-1:0]       r_a;
  logic [M-1:0]       r_b;
  logic [M-1:0]       r_acc;
  logic [M-1:0]       r_z;
  logic [CNT_W-1:0]   r_cnt;
  logic [D-1:0]       w_digit;
  logic [M-1:0]       w_acc_nxt;

  // Multiply by x and reduce: shift left, fold the x^M overflow via POLY.
  function automatic logic [M-1:0] xt(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  // One digit of Horner evaluation: acc = acc*x + bit*a, for each bit of
  // the digit from its MSB down.
  function automatic logic [M-1:0] digit_step(input logic [M-1:0] acc,
                                              input logic [M-1:0] a,
                                              input logic [D-1:0] dig);
    logic [M-1:0] v;
    v = acc;
    for (int j = D - 1; j >= 0; j--) begin
      v = xt(v) ^ (dig[j] ? a : '0);
    end
    return v;
  endfunction

  assign w_digit   = r_b[M-1 -: D];
  assign w_acc_nxt = digit_step(r_acc, r_a, w_digit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(NCYC - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so out_ready_i never reaches
  // in_ready_o combinationally.
  assign bus.in_ready_o  = (r_state == ST_IDLE);
  assign bus.out_valid_o = (r_state == ST_DONE);
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.z_o         = r_z;

  // Operands are captured only on the accept edge; r_z holds the last
  // product until the next one completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_z   <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a_i;
      r_b   <= bus.b_i;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_nxt;
      r_b   <= r_b << D;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_z <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gf_mul_ds.sv
// ---------------------------------------------------------------------------
// tb_gf_mul_ds : bench for gf_mul_ds. Slots 0..3 are M=8, POLY=0x1D with
// D=1,2,4,8; slot 4 is M=4, POLY=0x3, D=2. Expected products come from
// hand-worked constants and a carry-less multiply-then-reduce model.
// ---------------------------------------------------------------------------
module tb_gf_mul_ds;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] in_valid;
  logic [4:0] out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [4:0] out_valid;
  logic [4:0] in_ready;
  logic [4:0] busy;
  logic [7:0] z [5];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_d
    gf_mul_ds_if #(.M(8)) bus ();
    gf_mul_ds #(.M(8), .POLY(8'h1D), .D(1 << g)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
    );
    assign bus.in_valid_i  = in_valid[g];
    assign bus.out_ready_i = out_ready[g];
    assign bus.a_i         = a;
    assign bus.b_i         = b;
    assign out_valid[g]    = bus.out_valid_o;
    assign in_ready[g]     = bus.in_ready_o;
    assign busy[g]         = bus.busy_o;
    assign z[g]            = bus.z_o;
  end

  gf_mul_ds_if #(.M(4)) bus4 ();
  gf_mul_ds #(.M(4), .POLY(4'h3), .D(2)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4.slave)
  );
  assign bus4.in_valid_i  = in_valid[4];
  assign bus4.out_ready_i = out_ready[4];
  assign bus4.a_i         = a[3:0];
  assign bus4.b_i         = b[3:0];
  assign out_valid[4]     = bus4.out_valid_o;
  assign in_ready[4]      = bus4.in_ready_o;
  assign busy[4]          = bus4.busy_o;
  assign z[4]             = {4'h0, bus4.z_o};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full carry-less product, then fold high bits with 0x11D.
  function automatic logic [7:0] gf8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ (16'(x) << i);
    end
    for (int i = 15; i >= 8; i--) begin
      if (p[i]) p = p ^ (16'h011D << (i - 8));
    end
    return p[7:0];
  endfunction

  // Wait for out_valid on slot k, counting edges from the accept edge.
  task automatic wait_result(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int k, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] exp_z, input int exp_lat,
                        input string tag);
    int lat;
    @(negedge clk);
    a           = aa;
    b           = bb;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    a           = ~aa;
    b           = ~bb;
    wait_result(k, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " z"}, z[k], exp_z);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check({tag, " valid_after_hs"}, out_valid[k], 1'b0);
    check({tag, " ready_after_hs"}, in_ready[k], 1'b1);
    check({tag, " z_held"}, z[k], exp_z);
  endtask

  initial begin
    int         lat;
    int         stray;
    logic [7:0] aa;
    logic [7:0] bb;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready",  in_ready[0],  1'b1);
    check("reset out_valid", out_valid[0], 1'b0);
    check("reset busy",      busy[0],      1'b0);
    check("reset z",         z[0],         8'h00);
    check("reset m4 ready",  in_ready[4],  1'b1);
    rst = 1'b0;

    run_op(0, 8'h02, 8'h80, 8'h1D, 8, "d1 02x80");
    run_op(0, 8'h80, 8'h80, 8'h13, 8, "d1 80x80");
    run_op(0, 8'h01, 8'hAB, 8'hAB, 8, "d1 01xAB");
    run_op(0, 8'h00, 8'h5C, 8'h00, 8, "d1 00x5C");
    run_op(3, 8'h80, 8'h80, 8'h13, 1, "d8 80x80");
    run_op(4, 8'h08, 8'h02, 8'h03, 2, "m4 8x2");
    run_op(4, 8'h0F, 8'h0F, 8'h0A, 2, "m4 FxF");

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 160; i++) begin
        case (i)
          0:       begin aa = 8'hFF; bb = 8'hFF; end
          1:       begin aa = 8'h01; bb = 8'hFF; end
          2:       begin aa = 8'hFF; bb = 8'h00; end
          default: begin aa = 8'($urandom); bb = 8'($urandom); end
        endcase
        run_op(k, aa, bb, gf8(aa, bb), 8 >> k, $sformatf("sweep k%0d %02hx*%02hx", k, aa, bb));
      end
    end

    // Backpressure: result must sit in DONE while the consumer stalls.
    @(negedge clk);
    a           = 8'h02;
    b           = 8'h80;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_result(0, lat);
    check("bp latency", lat, 8);
    for (int c = 0; c < 20; c++) begin
      in_valid[0] = c[0];
      a           = 8'($urandom);
      b           = 8'($urandom);
      @(negedge clk);
      check("bp out_valid", out_valid[0], 1'b1);
      check("bp z",         z[0],         8'h1D);
      check("bp in_ready",  in_ready[0],  1'b0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp release ready", in_ready[0],  1'b1);
    check("bp release busy",  busy[0],      1'b0);
    check("bp release valid", out_valid[0], 1'b0);

    // Asynchronous reset in the middle of a D=1 calculation (cnt=3).
    @(negedge clk);
    a           = 8'h55;
    b           = 8'hFF;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", out_valid[0], 1'b0);
    check("async rst busy",  busy[0],      1'b0);
    check("async rst ready", in_ready[0],  1'b1);
    check("async rst z",     z[0],         8'h00);
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0]) stray++;
    end
    check("no valid after rst", stray, 0);
    run_op(0, 8'h03, 8'h07, 8'h09, 8, "d1 03x07");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
